// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: MAC over inputs and weights, bias, round, saturate, stream out.
// Build option FC_RELU_EN clamps negative results to zero (ReLU); otherwise results pass signed.
module fc_layer_sequencer #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int ADDR_W    = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W:0]       num_in,
  input  logic [ADDR_W:0]       num_out,
  output logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_data,
  output logic [2*ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]     w_data,
  output logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  // state | meaning: IDLE wait start | MAC read k | DRAIN last product, bias read
  //                  BIAS round/saturate | WRITE hold result | DONE completion pulse
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_BIAS, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W:0] ONE_N = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     state;
  logic [ADDR_W:0]            n_in, n_out;
  logic [ADDR_W-1:0]          o;
  logic [2*ADDR_W-1:0]        base;
  logic signed [ACC_W-1:0]    acc;

  logic signed [2*DATA_W-1:0] in_ext, w_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, sum, rnd, shifted;
  logic [DATA_W-1:0]          res, res_act;
  logic [2*ADDR_W-1:0]        n_in_ext;
  logic                       last_k, last_o;

  assign n_in_ext = {{(ADDR_W-1){1'b0}}, n_in};
  assign last_k   = ({1'b0, in_addr} == (n_in - ONE_N));
  assign last_o   = ({1'b0, o} == (n_out - ONE_N));

  always_comb begin
    in_ext   = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    w_ext    = {{DATA_W{w_data[DATA_W-1]}}, w_data};
    prod     = in_ext * w_ext;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){b_data[DATA_W-1]}}, b_data, {FRAC_BITS{1'b0}}};
    sum      = acc + bias_ext;
    rnd      = sum + HALF;
    shifted  = rnd >>> FRAC_BITS;
    if (shifted > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
    else                        res = shifted[DATA_W-1:0];
`ifdef FC_RELU_EN
    res_act = res[DATA_W-1] ? '0 : res;
`else
    res_act = res;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      n_in      <= '0;
      n_out     <= '0;
      o         <= '0;
      base      <= '0;
      acc       <= '0;
      in_addr   <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_in  <= num_in;
            n_out <= num_out;
            if (num_in == '0 || num_out == '0) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              err     <= 1'b0;
              busy    <= 1'b1;
              o       <= '0;
              base    <= '0;
              acc     <= '0;
              in_addr <= '0;
              w_addr  <= '0;
              state   <= S_MAC;
            end
          end
        end
        S_MAC: begin
          // Data for the previous address arrives now; the first cycle has none.
          if (in_addr != '0) acc <= acc + prod_ext;
          if (last_k) begin
            b_addr <= o;
            state  <= S_DRAIN;
          end else begin
            in_addr <= in_addr + ADDR_W'(1);
            w_addr  <= w_addr + (2*ADDR_W)'(1);
          end
        end
        S_DRAIN: begin
          acc   <= acc + prod_ext;
          state <= S_BIAS;
        end
        S_BIAS: begin
          out_data  <= res_act;
          out_addr  <= o;
          out_valid <= 1'b1;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            base      <= base + n_in_ext;
            o         <= o + ADDR_W'(1);
            acc       <= '0;
            in_addr   <= '0;
            w_addr    <= base + n_in_ext;
            if (last_o) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              state <= S_MAC;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: memory models, arithmetic reference, decoupled output monitor.
module tb_fc_layer_sequencer;
  localparam int DW = 16;
  localparam int AW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset, start, abort, out_ready;
  logic [AW:0]     num_in, num_out;
  logic [AW-1:0]   in_addr, b_addr, out_addr;
  logic [2*AW-1:0] w_addr;
  logic [DW-1:0]   in_data, w_data, b_data, out_data;
  logic            out_valid, busy, done, err;

  logic [DW-1:0] in_mem [0:1023];
  logic [DW-1:0] w_mem  [0:4095];
  logic [DW-1:0] b_mem  [0:1023];

  exp_t            q[$];
  logic [2*AW-1:0] wtrace[$];
  bit              trace_en = 0;
  int n_cmp = 0, n_bad = 0, done_cnt = 0, pops = 0;
  int ready_mode = 0, stall_n = 0, cyc = 0;

  fc_layer_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .num_in(num_in), .num_out(num_out),
    .in_addr(in_addr), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data),
    .out_addr(out_addr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr[11:0]];
    b_data  <= b_mem[b_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Output monitor: every presented result must match the scoreboard head until accepted.
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (trace_en && busy && (wtrace.size() == 0 || wtrace[wtrace.size()-1] !== w_addr))
      wtrace.push_back(w_addr);
    if (!reset && out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      else begin
        chk("out_addr", {22'd0, out_addr}, {22'd0, q[0].addr});
        chk("out_data", {16'd0, out_data}, {16'd0, q[0].data});
        if (out_ready) begin
          q.delete(0);
          pops++;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      cyc++;
      case (ready_mode)
        1: if (out_valid && out_addr == 1 && stall_n < 5) begin
             out_ready = 1'b0;
             stall_n++;
           end else out_ready = 1'b1;
        2: out_ready = cyc[1];
        3: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Reference: plain signed arithmetic with the 40-bit wrap, half-up rounding and saturation.
  function automatic logic [DW-1:0] model(input int ni, input int o);
    longint acc = 0, sum, r;
    logic signed [DW-1:0] a, b;
    for (int k = 0; k < ni; k++) begin
      a = in_mem[k];
      b = w_mem[o*ni + k];
      acc = acc + longint'(a) * longint'(b);
      acc = (acc <<< 24) >>> 24;
    end
    b = b_mem[o];
    sum = acc + longint'(b) * 256;
    sum = (sum <<< 24) >>> 24;
    sum = sum + 128;
    sum = (sum <<< 24) >>> 24;
    r = sum >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef FC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rv();
    logic [DW-1:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 1) == 1) v = {{6{v[9]}}, v[9:0]};
    return v;
  endfunction

  task automatic rand_mems(input int ni, input int no);
    for (int k = 0; k < ni; k++) in_mem[k] = rv();
    for (int j = 0; j < ni*no; j++) w_mem[j] = rv();
    for (int o = 0; o < no; o++) b_mem[o] = rv();
  endtask

  task automatic push_exp(input int a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = AW'(a);
    e.data = d;
    q.push_back(e);
  endtask

  task automatic do_start(input int ni, input int no);
    num_in  = (AW+1)'(ni);
    num_out = (AW+1)'(no);
    start   = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int c);
    c = 0;
    @(negedge clock);
    while (!done && c < budget) begin
      c++;
      @(negedge clock);
    end
    if (!done) chk({nm, "_timeout"}, {31'd0, done}, 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic run_layer(input string nm, input int ni, input int no, input int mode,
                           input bit use_model, output int c);
    int d0;
    if (use_model) for (int o = 0; o < no; o++) push_exp(o, model(ni, o));
    ready_mode = mode;
    stall_n = 0;
    d0 = done_cnt;
    do_start(ni, no);
    chk({nm, "_busy_rise"}, {31'd0, busy}, 32'd1);
    wait_done(nm, 40*no*(ni+3) + 20, c);
    chk({nm, "_done_cnt"}, done_cnt - d0, 32'd1);
    chk({nm, "_drained"}, q.size(), 32'd0);
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int c, d0, p0, n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_in = '0; num_out = '0;
    for (int i = 0; i < 1024; i++) begin in_mem[i] = '0; b_mem[i] = '0; end
    for (int i = 0; i < 4096; i++) w_mem[i] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_addrs", {2'd0, in_addr, w_addr} | {22'd0, b_addr} | {22'd0, out_addr} | {16'd0, out_data}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    in_mem[0] = 16'h0100; in_mem[1] = 16'h0200;
    w_mem[0]  = 16'h0100; w_mem[1]  = 16'h0080; b_mem[0] = 16'h0100;
    push_exp(0, 16'h0300);
    run_layer("basic", 2, 1, 0, 0, c);
    chk("basic_latency", c, 5);

    for (int k = 0; k < 4; k++) begin in_mem[k] = 16'h7FFF; w_mem[k] = 16'h7FFF; end
    b_mem[0] = 16'h0000;
    push_exp(0, 16'h7FFF);
    run_layer("sat_pos", 4, 1, 0, 0, c);
    for (int k = 0; k < 4; k++) w_mem[k] = 16'h8001;
`ifdef FC_RELU_EN
    push_exp(0, 16'h0000);
`else
    push_exp(0, 16'h8000);
`endif
    run_layer("sat_neg", 4, 1, 0, 0, c);

    in_mem[0] = 16'h0100; w_mem[0] = 16'hFF00; b_mem[0] = 16'h0000;
`ifdef FC_RELU_EN
    push_exp(0, 16'h0000);
`else
    push_exp(0, 16'hFF00);
`endif
    run_layer("activation", 1, 1, 0, 0, c);

    rand_mems(3, 4);
    wtrace.delete();
    trace_en = 1;
    run_layer("multi", 3, 4, 1, 1, c);
    trace_en = 0;
    chk("stall_cycles", stall_n, 5);
    chk("w_addr_len", wtrace.size(), 12);
    for (int i = 0; i < wtrace.size() && i < 12; i++) chk("w_addr_seq", {12'd0, wtrace[i]}, i);

    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    d0 = done_cnt;
    do_start(0, 5);
    @(negedge clock);
    chk("zero_err", {31'd0, err}, 1);
    chk("zero_done", {31'd0, done}, 1);
    chk("zero_busy", {31'd0, busy}, 0);
    @(negedge clock);
    chk("zero_done_pulse", {31'd0, done}, 0);
    chk("zero_err_sticky", {31'd0, err}, 1);
    chk("zero_no_reads", {2'd0, in_addr, w_addr} | {22'd0, b_addr}, 0);
    @(posedge clock); #1;
    chk("zero_done_cnt", done_cnt - d0, 1);
    rand_mems(2, 2);
    run_layer("clear_err", 2, 2, 0, 1, c);
    chk("err_cleared", {31'd0, err}, 0);

    for (int variant = 0; variant < 2; variant++) begin
      rand_mems(4, 4);
      for (int o = 0; o < 4; o++) push_exp(o, model(4, o));
      ready_mode = 2;
      p0 = pops;
      d0 = done_cnt;
      do_start(4, 4);
      n = 0;
      while (pops - p0 < 2 && n < 500) begin
        @(posedge clock); #1;
        n++;
      end
      chk("cancel_reach_n2", pops - p0, 2);
      if (variant == 0) abort = 1'b1; else reset = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      q.delete();
      if (variant == 0) begin
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_valid", {31'd0, out_valid}, 0);
        chk("abort_done", {31'd0, done}, 0);
      end else begin
        chk("rst_mid_flags", {28'd0, busy, done, out_valid, err}, 0);
        chk("rst_mid_addrs", {2'd0, in_addr, w_addr} | {22'd0, b_addr} | {22'd0, out_addr} | {16'd0, out_data}, 0);
        reset = 1'b0;
      end
      repeat (30) @(posedge clock);
      #1;
      chk("cancel_no_done", done_cnt - d0, 0);
    end

    rand_mems(3, 2);
    for (int o = 0; o < 2; o++) push_exp(o, model(3, o));
    ready_mode = 3;
    d0 = done_cnt;
    do_start(3, 2);
    @(posedge clock); #1;
    num_in = 7; num_out = 1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("busy_start", 400, c);
    chk("busy_start_done_cnt", done_cnt - d0, 1);
    chk("busy_start_drained", q.size(), 0);

    for (int t = 0; t < 6; t++) begin
      int ni, no;
      ni = $urandom_range(1, 6);
      no = $urandom_range(1, 4);
      rand_mems(ni, no);
      run_layer("random", ni, no, 3, 1, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
Control FSM that runs one fully-connected layer on the Fully_Connected IP datapath. Start, num_in and num_out come from the S00_AXI register file. The block walks the input, weight and bias memories, accumulates signed fixed-point products, applies bias, rounding shift and saturation, then streams each neuron result to the output buffer. It reports busy, done and error back to the register file.

Parameters:
DATA_W, 16, signed Q-format width of inputs, weights, bias and outputs
FRAC_BITS, 8, fractional bits of the Q-format
ACC_W, 40, signed accumulator width
ADDR_W, 10, address width of each memory; num_in and num_out are ADDR_W+1 bits wide

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse from control register
abort  in  1  one-cycle pulse; cancels the layer
num_in  in  ADDR_W+1  inputs per neuron
num_out  in  ADDR_W+1  neurons in the layer
in_addr  out  ADDR_W  input memory read address
in_data  in  DATA_W  input memory data; 1-cycle read latency
w_addr  out  2*ADDR_W  weight memory address, o*num_in+k
w_data  in  DATA_W  weight memory data; 1-cycle read latency
b_addr  out  ADDR_W  bias memory address
b_data  in  DATA_W  bias memory data; 1-cycle read latency
out_addr  out  ADDR_W  neuron index of the result
out_data  out  DATA_W  result
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  output buffer accepts the result
busy  out  1  layer in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky; set on zero-length start, cleared by the next start

Behaviour:
- Reset: state IDLE; all counters and accumulator 0; busy, done, out_valid and err are 0; all address outputs 0.
- Operands num_in and num_out are latched on an accepted start. Later changes to the inputs are ignored until the next start.
- IDLE:
  - start with num_in==0 or num_out==0 -> set err, pulse done next cycle, no memory traffic.
  - start otherwise -> clear err, go to MAC. busy rises the cycle after start.
- MAC: one cycle per k = 0..num_in-1.
  - Drives in_addr=k and w_addr=base+k, where base is a running o*num_in register. No multiplier is used on the address path.
  - Data returned in cycle k+1 gives product in_data*w_data (2*DATA_W, signed). The product is sign-extended and added to acc.
  - acc is cleared at neuron entry and wraps modulo 2^ACC_W; no intermediate saturation.
  - After k==num_in-1 -> DRAIN.
- DRAIN: one cycle. Accumulates the last product and drives b_addr=o.
- BIAS: one cycle.
  - sum = acc + (sign-extended b_data << FRAC_BITS).
  - res = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half up.
  - res saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - res is registered into out_data, out_addr=o, out_valid=1, then go to WRITE.
- WRITE:
  - out_valid, out_data and out_addr stay stable until out_ready. Transfer happens on the cycle out_valid and out_ready are both high.
  - On transfer: out_valid=0; base += num_in; o++.
  - If o was num_out-1 -> DONE, else -> MAC.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Per-neuron latency is num_in+3 cycles when out_ready is held high.
- start while busy is ignored.
- abort in any non-IDLE state:
  - Next cycle: IDLE, out_valid=0, busy=0, no done, err unchanged.
  - abort has priority over a simultaneous transfer, and the result is dropped.
- reset mid-operation gives reset values on the next edge. No partial output is written afterwards.

Optional Feature:
Macro FC_RELU_EN.
- Defined: after saturation, negative res is forced to 0 before out_data, i.e. a ReLU activation.
- Undefined: res is output signed, unmodified. Port list is identical in both builds.

Test Plan:
- Basic result: num_in=2, num_out=1, in=[0x0100,0x0200], w=[0x0100,0x0080], bias=0x0100, out_ready=1.
  -> one write, out_addr=0, out_data=0x0300.
  -> done exactly 5 cycles after the first MAC cycle.
- Saturation: num_in=4, num_out=1, all in=w=0x7FFF, bias=0 -> out_data=0x7FFF.
  - Same test with w=0x8001 -> out_data=0x8000.
- Activation: num_in=1, in=0x0100, w=0xFF00, bias=0.
  - -> out_data=0xFF00 without FC_RELU_EN.
  - -> out_data=0x0000 with FC_RELU_EN.
- Multi-neuron with back-pressure: num_in=3, num_out=4, out_ready low for 5 cycles on neuron 1.
  - -> results written in order out_addr 0,1,2,3, each matching the reference model.
  - -> out_data stable while stalled.
  - -> w_addr sequence 0..11 contiguous.
- Zero length: start with num_in=0, num_out=5 -> err=1, done pulse 1 cycle later, no out_valid, no reads.
  - A following valid start clears err.
- Abort and reset: abort asserted in the MAC state of neuron 2 of 4, with 2-cycle pulsed out_ready.
  - -> IDLE next cycle, no done, no further out_valid.
  - Repeat the test with reset instead of abort -> all outputs 0 on the next edge.
  - start during busy -> no effect on num_in, num_out or the result.
